// File: rtl/norm_shift.sv
// norm_shift: two-stage normalizer that left-justifies a mantissa using an external leading-zero count
module norm_shift #(
  parameter int XLEN = 64,
  parameter int XLOG = 6,
  parameter int ELEN = 13
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_mant,
  input  logic [ELEN-1:0] in_exp,
  input  logic [XLOG-1:0] in_c,
  input  logic            in_v,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_mant,
  output logic [ELEN-1:0] out_exp,
  output logic            out_tiny,
  output logic            out_zero
);
  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s1_mant_q, s1_mant_d, out_mant_q, out_mant_d;
  logic [XLOG-1:0] s1_sh_q, s1_sh_d;
  logic [ELEN-1:0] s1_exp_q, s1_exp_d, out_exp_q, out_exp_d;
  logic            s1_tiny_q, s1_tiny_d, s1_zero_q, s1_zero_d;
  logic            out_tiny_q, out_tiny_d, out_zero_q, out_zero_d;
  logic            s2_ready, in_fire, s1_fire, big;
  logic [XLOG-1:0] lz_n;
  logic [ELEN-1:0] lz;

  // handshake chain plus stage-1 decode of the shift amount and exponent clamp
  always_comb begin
    s2_ready   = !s2_valid_q | out_ready;
    in_ready   = !s1_valid_q | s2_ready;
    in_fire    = in_valid & in_ready;
    s1_fire    = s1_valid_q & s2_ready;
    lz_n       = ~in_c;
    lz         = ELEN'(lz_n);
    big        = in_exp > lz;
    s1_valid_d = in_fire | (s1_valid_q & !s2_ready);
    s2_valid_d = s1_fire | (s2_valid_q & !out_ready);
    s1_mant_d  = in_fire ? in_mant : s1_mant_q;
    s1_zero_d  = in_fire ? !in_v : s1_zero_q;
    s1_tiny_d  = in_fire ? in_v & !big : s1_tiny_q;
    s1_sh_d    = in_fire ? (!in_v ? '0 : big ? lz_n : in_exp[XLOG-1:0]) : s1_sh_q;
    s1_exp_d   = in_fire ? (in_v & big ? in_exp - lz : '0) : s1_exp_q;
    out_mant_d = s1_fire ? s1_mant_q << s1_sh_q : out_mant_q;
    out_exp_d  = s1_fire ? s1_exp_q : out_exp_q;
    out_tiny_d = s1_fire ? s1_tiny_q : out_tiny_q;
    out_zero_d = s1_fire ? s1_zero_q : out_zero_q;
  end

  // pipeline registers; reset drops both stages so in-flight beats vanish
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_sh_q    <= '0;
      s1_exp_q   <= '0;
      s1_tiny_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
      out_tiny_q <= 1'b0;
      out_zero_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_sh_q    <= s1_sh_d;
      s1_exp_q   <= s1_exp_d;
      s1_tiny_q  <= s1_tiny_d;
      s1_zero_q  <= s1_zero_d;
      out_mant_q <= out_mant_d;
      out_exp_q  <= out_exp_d;
      out_tiny_q <= out_tiny_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_tiny  = out_tiny_q;
  assign out_zero  = out_zero_q;
endmodule

// File: doc/norm_shift.md
Name: norm_shift

Overview:
- Two-stage pipelined normalizer sitting directly downstream of the lzc_N leading-zero counters.
- Accepts a raw mantissa, its biased exponent, and the lzc_N result for that mantissa (c, v).
- Left-shifts the mantissa so its MSB is 1 and reduces the exponent by the shift amount.
- Clamps at exponent 0 (tiny/subnormal result) and flags all-zero mantissas.
- Feeds the rounding stage through a valid/ready handshake.

Parameters:
- XLEN, 64, mantissa width (4/8/16/32/64/128/256, matching the available lzc_N).
- XLOG, 6, log2(XLEN); width of the lzc count.
- ELEN, 13, biased exponent width (unsigned).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input this cycle.
- in_mant  in  XLEN  unnormalized mantissa.
- in_exp  in  ELEN  biased exponent of in_mant.
- in_c  in  XLOG  lzc_N c output for in_mant; leading-zero count lz = ~in_c.
- in_v  in  1  lzc_N v output; 1 = in_mant nonzero, 0 = in_mant all zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output.
- out_mant  out  XLEN  normalized (or partially normalized) mantissa.
- out_exp  out  ELEN  adjusted exponent.
- out_tiny  out  1  exponent clamped at 0; mantissa not fully normalized.
- out_zero  out  1  input mantissa was zero.

Behaviour:
- Reset (reset=0, async): s1_valid=0, s2_valid=0, so out_valid=0 and in_ready=1. out_mant, out_exp, out_tiny and out_zero reset to 0. Any beats in flight are discarded, with no partial output after reset release.
- Handshake: a transfer occurs when valid&ready are both high on a clock edge. out_* stay stable while out_valid=1 and out_ready=0. in_ready depends only on internal state and out_ready; it never depends on in_valid.
- Ready chain:
  - s2_ready = !s2_valid | out_ready
  - in_ready = !s1_valid | s2_ready
  - Full throughput is 1 beat/cycle; latency is 2 cycles (input edge N gives out_valid at edge N+2).
- Stage 1 (register on input transfer):
  - lz = ~in_c, zero-extended to ELEN.
  - If in_v=0: zero=1, sh=0, exp1=0, tiny=0.
  - Else if in_exp > lz: sh=lz, exp1=in_exp-lz, tiny=0.
  - Else (in_exp <= lz): sh=in_exp[XLOG-1:0], exp1=0, tiny=1. in_exp <= lz <= XLEN-1 guarantees sh fits.
  - Registers held: mant, sh, exp1, tiny, zero, s1_valid.
- Stage 2 (register when s2_ready & s1_valid): out_mant = s1_mant << sh (logical, zero fill, width XLEN). out_exp, out_tiny and out_zero are copied from stage 1.
- Stage valid updates:
  - s1_valid <= in_valid&in_ready ? 1 : (s2_ready ? 0 : s1_valid)
  - s2_valid <= s1_valid&s2_ready ? 1 : (out_ready ? 0 : s2_valid)
- Simultaneous accept and drain in the same cycle is legal at both stages (no bubble).
- Boundary conditions:
  - in_exp=lz+1 gives exp 1, not tiny.
  - in_exp=lz gives tiny, shift by lz, exp 0; MSB lands at bit XLEN-1 but tiny=1 per rule.
  - Mantissa with MSB already set: lz=0, sh=0, exp unchanged; if in_exp=0, tiny=1 and sh=0.
  - in_v=0 ignores in_c and in_exp.
- No internal lzc instance: in_c/in_v are driven combinationally by an external lzc_N on the same in_mant.

Test Plan:
- Reset mid-flight: two beats accepted, then reset=0 between edges -> out_valid drops to 0 asynchronously; after release, no stale beat appears; in_ready=1.
- Full shift: in_mant=0x0000_0000_0000_0001, in_c=6'h00 (lz=63), in_exp=100 -> two cycles later out_mant=0x8000_0000_0000_0000, out_exp=37, out_tiny=0, out_zero=0.
- Tiny clamp: in_mant=0x00F0_0000_0000_0000, in_c=6'h37 (lz=8), in_exp=5 -> out_mant=0x1E00_0000_0000_0000, out_exp=0, out_tiny=1.
- Zero: in_mant=0, in_v=0, in_exp=1234 -> out_mant=0, out_exp=0, out_zero=1, out_tiny=0.
- Backpressure: out_ready=0 and three consecutive in_valid beats A,B,C -> A and B accepted, in_ready=0 while C is held. out_ready=1 -> A, B, C emerge in order, each stable while stalled, none lost or duplicated.
- Streaming: 64 back-to-back beats using the lzc sweep pattern (single bit shifted from bit 0 to bit 63, in_exp=200) with out_ready=1 -> one output per cycle after 2-cycle fill; every out_mant=0x8000_0000_0000_0000 and out_exp=200-lz.
